// File: rtl/hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Shared definitions for the D-stage hazard/stall unit of the pipelined MIPS
// core.
// Contents:
//   - default pipeline depth, timing-field width, MDU latencies and stall
//     counter width
//   - stage index constants (0 = register file, 1 = youngest pipeline stage)
//   - tuse_none_code(): the "source not used" tuse encoding for a given
//     field width, which is all ones (2^TW-1)
// ---------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    // Default configuration
    localparam int DEF_NSTAGE   = 3;
    localparam int DEF_TW       = 2;
    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;
    localparam int DEF_CW       = 32;

    // Stage indices: a forwarding hint of STG_RF means "read the register file"
    localparam int STG_RF    = 0;
    localparam int STG_FIRST = 1;

    // All-ones tuse value marks a source operand that is never read
    function automatic int unsigned tuse_none_code(input int unsigned tw);
        tuse_none_code = (32'd1 << tw) - 32'd1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_mdu_countdown.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_mdu_countdown
// Busy countdown for the multi-cycle multiply/divide unit.
// A start loads the latency of the requested operation class. Otherwise the
// counter decrements while it is nonzero.
// Ports:
//   clk     in  clock
//   reset_n in  asynchronous active-low reset (clears the count)
//   start   in  accepted MDU start; the caller has already qualified it with
//               valid and no-stall
//   div     in  the started operation is a divide (selects DIV_LAT)
//   busy    out the count is nonzero
// ---------------------------------------------------------------------------
module hazard_scoreboard_mdu_countdown
    import hazard_scoreboard_pkg::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic div,
    output logic busy
);

    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CNTW    = $clog2(MAX_LAT + 1);

    logic [CNTW-1:0] cnt_r;
    logic [CNTW-1:0] lat_s;

    // Latency select for the operation class being started
    always_comb begin
        lat_s = CNTW'(MULT_LAT);
        if (div) begin
            lat_s = CNTW'(DIV_LAT);
        end else begin
            lat_s = CNTW'(MULT_LAT);
        end
    end

    // Countdown register: load on start, otherwise run down to zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CNTW{1'b0}};
        end else if (start) begin
            cnt_r <= lat_s;
        end else if (cnt_r != {CNTW{1'b0}}) begin
            cnt_r <= cnt_r - {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign busy = (cnt_r != {CNTW{1'b0}});

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// D-stage hazard and stall unit. In-flight register writers are tracked in an
// NSTAGE-deep shift register of {valid, dest, tnew}. Stage 1 is the youngest
// entry. Each source of the D instruction is matched against the youngest
// writer of the same register to decide stall and forwarding. A countdown
// blocks MDU users while a multiply/divide is in progress.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   d_valid             D holds a real instruction
//   d_rs/d_rt           source registers
//   d_tuse_rs/d_tuse_rt cycles until each source is needed (all ones = unused)
//   d_wr/d_a3/d_tnew    destination write enable, register, result-ready time
//   d_mdu_dep           instruction needs an idle MDU
//   d_mdu_start/div     instruction starts an MDU op (divide when div set)
//   flush               synchronous scoreboard clear
//   stall               hold F/D, bubble into stage 1 (combinational)
//   fwd_rs/fwd_rt       youngest matching stage, 0 = register file
//   mdu_busy            MDU countdown nonzero
//   stall_cnt           saturating count of stalled cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSTAGE   = DEF_NSTAGE,
    parameter int TW       = DEF_TW,
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT,
    parameter int CW       = DEF_CW
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             d_valid,
    input  logic [4:0]                       d_rs,
    input  logic [4:0]                       d_rt,
    input  logic [TW-1:0]                    d_tuse_rs,
    input  logic [TW-1:0]                    d_tuse_rt,
    input  logic                             d_wr,
    input  logic [4:0]                       d_a3,
    input  logic [TW-1:0]                    d_tnew,
    input  logic                             d_mdu_dep,
    input  logic                             d_mdu_start,
    input  logic                             d_mdu_div,
    input  logic                             flush,
    output logic                             stall,
    output logic [$clog2(NSTAGE+1)-1:0]      fwd_rs,
    output logic [$clog2(NSTAGE+1)-1:0]      fwd_rt,
    output logic                             mdu_busy,
    output logic [CW-1:0]                    stall_cnt
);

    localparam int              FW        = $clog2(NSTAGE + 1);
    localparam logic [TW-1:0]   TUSE_NONE = TW'(tuse_none_code(TW));

    // Saturating decrement of a result-ready countdown
    function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
        if (t == {TW{1'b0}}) begin
            tnew_dec = t;
        end else begin
            tnew_dec = t - {{(TW-1){1'b0}}, 1'b1};
        end
    endfunction

    // Flattened view of the scoreboard, index 1 = youngest
    logic [NSTAGE:1] v_s;
    logic [4:0]      a3_s   [1:NSTAGE];
    logic [TW-1:0]   tnew_s [1:NSTAGE];

    logic            stall_s;
    logic            mdu_busy_s;
    logic            mdu_start_ok_s;
    logic [CW-1:0]   stall_cnt_r;

    logic            rs_hit_s, rt_hit_s;
    logic [FW-1:0]   rs_idx_s, rt_idx_s;
    logic [TW-1:0]   rs_tnew_s, rt_tnew_s;
    logic            rs_act_s, rt_act_s;
    logic            rs_stall_s, rt_stall_s, mdu_stall_s;

    for (genvar k = 1; k <= NSTAGE; k++) begin : g_stage
        logic          v_r;
        logic [4:0]    a3_r;
        logic [TW-1:0] tnew_r;

        if (k == STG_FIRST) begin : g_load
            // Youngest entry: take the D-stage writer, or a bubble on stall/flush
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    v_r    <= 1'b0;
                    a3_r   <= 5'd0;
                    tnew_r <= {TW{1'b0}};
                end else if (flush) begin
                    v_r    <= 1'b0;
                    a3_r   <= d_a3;
                    tnew_r <= d_tnew;
                end else begin
                    v_r    <= d_valid & d_wr & (d_a3 != 5'd0) & ~stall_s;
                    a3_r   <= d_a3;
                    tnew_r <= d_tnew;
                end
            end
        end else begin : g_shift
            // Older entries: advance from the previous stage, ageing tnew
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    v_r    <= 1'b0;
                    a3_r   <= 5'd0;
                    tnew_r <= {TW{1'b0}};
                end else if (flush) begin
                    v_r    <= 1'b0;
                    a3_r   <= a3_s[k-1];
                    tnew_r <= tnew_dec(tnew_s[k-1]);
                end else begin
                    v_r    <= v_s[k-1];
                    a3_r   <= a3_s[k-1];
                    tnew_r <= tnew_dec(tnew_s[k-1]);
                end
            end
        end

        assign v_s[k]    = v_r;
        assign a3_s[k]   = a3_r;
        assign tnew_s[k] = tnew_r;
    end

    // Youngest-match search: scan oldest to youngest so the youngest hit wins
    always_comb begin
        rs_hit_s  = 1'b0;
        rs_idx_s  = FW'(STG_RF);
        rs_tnew_s = {TW{1'b0}};
        rt_hit_s  = 1'b0;
        rt_idx_s  = FW'(STG_RF);
        rt_tnew_s = {TW{1'b0}};
        for (int k = NSTAGE; k >= STG_FIRST; k--) begin
            if (v_s[k] && (a3_s[k] == d_rs)) begin
                rs_hit_s  = 1'b1;
                rs_idx_s  = FW'(k);
                rs_tnew_s = tnew_s[k];
            end else begin
                rs_hit_s  = rs_hit_s;
            end
            if (v_s[k] && (a3_s[k] == d_rt)) begin
                rt_hit_s  = 1'b1;
                rt_idx_s  = FW'(k);
                rt_tnew_s = tnew_s[k];
            end else begin
                rt_hit_s  = rt_hit_s;
            end
        end
    end

    // $0 is never loaded as valid, but excluding it here also keeps fwd at 0
    assign rs_act_s    = d_valid & (d_tuse_rs != TUSE_NONE) & (d_rs != 5'd0);
    assign rt_act_s    = d_valid & (d_tuse_rt != TUSE_NONE) & (d_rt != 5'd0);
    assign rs_stall_s  = rs_act_s & rs_hit_s & (rs_tnew_s > d_tuse_rs);
    assign rt_stall_s  = rt_act_s & rt_hit_s & (rt_tnew_s > d_tuse_rt);
    assign mdu_stall_s = d_valid & (d_mdu_dep | d_mdu_start) & mdu_busy_s;
    assign stall_s     = rs_stall_s | rt_stall_s | mdu_stall_s;

    // A start that is itself stalled must not reload the countdown
    assign mdu_start_ok_s = d_valid & d_mdu_start & ~stall_s;

    hazard_scoreboard_mdu_countdown #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_mdu (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mdu_start_ok_s),
        .div     (d_mdu_div),
        .busy    (mdu_busy_s)
    );

    // Saturating stall-cycle counter; flush does not touch it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_r <= {CW{1'b0}};
        end else if (stall_s && (stall_cnt_r != {CW{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall     = stall_s;
    assign fwd_rs    = (rs_act_s & rs_hit_s) ? rs_idx_s : FW'(STG_RF);
    assign fwd_rt    = (rt_act_s & rt_hit_s) ? rt_idx_s : FW'(STG_RF);
    assign mdu_busy  = mdu_busy_s;
    assign stall_cnt = stall_cnt_r;

endmodule
